// File: rtl/axis_route_egress_dtu_if.sv
// AXI4-Stream bundle shared by the switch-side and region-side ports of the egress receiver.
interface axis_route_egress_dtu_if #(
  parameter int DATA_BITS = 512,
  parameter int PID_BITS  = 6,
  parameter int DEST_BITS = 8
);
  logic                   tvalid;
  logic                   tready;
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;
  logic [PID_BITS-1:0]    tid;
  logic [DEST_BITS-1:0]   tdest;

  modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_route_egress_dtu.sv
// Per-region egress receiver: forwards packets routed to MY_DEST through a
// registered output + skid buffer, drains and counts misrouted packets.
module axis_route_egress_dtu #(
  parameter int                   DATA_BITS = 512,
  parameter int                   PID_BITS  = 6,
  parameter int                   DEST_BITS = 8,
  parameter logic [DEST_BITS-1:0] MY_DEST   = 8'h5C,
  parameter int                   CNT_BITS  = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  axis_route_egress_dtu_if.slave  s_axis,
  axis_route_egress_dtu_if.master m_axis,
  output logic [DEST_BITS-1:0]  route_out,
  output logic [CNT_BITS-1:0]   pkt_cnt,
  output logic [CNT_BITS-1:0]   drop_cnt,
  output logic                  route_err,
  input  logic                  cnt_clr
);

  // state | meaning
  // IDLE  | waiting for the first beat of a packet; route decided from its tdest
  // PASS  | forwarding the rest of a matching packet
  // DROP  | discarding the rest of a misrouted packet
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  localparam int BW = DATA_BITS + DATA_BITS/8 + 1 + PID_BITS;

  logic [1:0]           state_q, state_d;
  logic [BW-1:0]        out_q, out_d, skid_q, skid_d;
  logic                 out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic [DEST_BITS-1:0] route_q, route_d, tag_q, tag_d;
  logic [CNT_BITS-1:0]  pkt_q, pkt_d, drop_q, drop_d;
  logic                 err_q, err_d;

  logic          match, s_rdy, accept, fwd, drp, out_free;
  logic [BW-1:0] in_beat;

  assign match    = (s_axis.tdest == MY_DEST);
  assign in_beat  = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tid};
  assign out_free = ~out_v_q | m_axis.tready;

  // Ready never looks at m_axis.tready; only the skid occupancy throttles input.
  always_comb begin
    s_rdy = 1'b0;
    case (state_q)
      IDLE:    s_rdy = s_axis.tvalid & (match ? ~skid_v_q : 1'b1);
      PASS:    s_rdy = ~skid_v_q;
      DROP:    s_rdy = 1'b1;
      default: s_rdy = 1'b0;
    endcase
    if (areset) s_rdy = 1'b0;
  end

  assign accept = s_axis.tvalid & s_rdy;
  assign fwd    = accept & ((state_q == PASS) | ((state_q == IDLE) & match));
  assign drp    = accept & ~fwd;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE:    if (!s_axis.tlast) state_d = match ? PASS : DROP;
        PASS,
        DROP:    if (s_axis.tlast) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Skid contents always move to the output stage before new input is taken.
  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (skid_v_q) begin
      if (out_free) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = 1'b0;
      end
    end else if (fwd) begin
      if (out_free) begin
        out_d   = in_beat;
        out_v_d = 1'b1;
      end else begin
        skid_d   = in_beat;
        skid_v_d = 1'b1;
      end
    end else if (out_free) begin
      out_v_d = 1'b0;
    end
  end

  always_comb begin
    route_d = route_q;
    tag_d   = tag_q;
    if (accept && state_q == IDLE) begin
      tag_d = s_axis.tdest;
      if (match) route_d = s_axis.tdest;
    end
  end

  always_comb begin
    pkt_d  = pkt_q;
    drop_d = drop_q;
    err_d  = err_q;
    if (fwd && s_axis.tlast && !(&pkt_q)) pkt_d = pkt_q + CNT_BITS'(1);
    if (drp && s_axis.tlast && !(&drop_q)) drop_d = drop_q + CNT_BITS'(1);
    if (accept && state_q != IDLE && s_axis.tdest != tag_q) err_d = 1'b1;
    if (cnt_clr) begin
      pkt_d  = '0;
      drop_d = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      route_q  <= '0;
      tag_q    <= '0;
      pkt_q    <= '0;
      drop_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      route_q  <= route_d;
      tag_q    <= tag_d;
      pkt_q    <= pkt_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = out_v_q;
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid} = out_q;
  assign m_axis.tdest  = route_q;
  assign route_out     = route_q;
  assign pkt_cnt       = pkt_q;
  assign drop_cnt      = drop_q;
  assign route_err     = err_q;

endmodule

// File: tb/tb_axis_route_egress_dtu.sv
// Directed bench for axis_route_egress_dtu: scoreboard of forwarded beats plus
// a small reference model of routing, counters and the route error flag.
module tb_axis_route_egress_dtu;
  localparam int DB = 512;
  localparam int KB = 64;
  localparam int PB = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_route_egress_dtu_if #(.DATA_BITS(DB), .PID_BITS(PB), .DEST_BITS(8)) s_if ();
  axis_route_egress_dtu_if #(.DATA_BITS(DB), .PID_BITS(PB), .DEST_BITS(8)) m_if ();

  logic [7:0]  route_out;
  logic [31:0] pkt_cnt, drop_cnt;
  logic        route_err, cnt_clr;

  axis_route_egress_dtu dut (
    .aclk(clk), .areset(rst), .s_axis(s_if), .m_axis(m_if),
    .route_out(route_out), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
    .route_err(route_err), .cnt_clr(cnt_clr)
  );

  typedef struct packed {
    logic [DB-1:0] d;
    logic [KB-1:0] k;
    logic          l;
    logic [PB-1:0] id;
  } beat_t;

  beat_t       exp_q[$];
  int          ncmp = 0, nfail = 0, n_out = 0, last_g = 0;
  int          mstate = 0;
  logic [7:0]  mtag = 8'h00;
  logic [31:0] exp_pkt = 0, exp_drop = 0;
  logic        exp_err = 1'b0;
  logic        s_acc = 1'b0, m_xfer = 1'b0, lat_chk = 1'b0, pushed_prev = 1'b0;

  task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    ncmp++;
    nfail++;
    $error("FAIL %s observed=timeout expected=progress", tag);
  endtask

  // One clock cycle: inputs already driven just after a falling edge.
  task automatic tick();
    beat_t e;
    logic  fwd;
    #1;
    s_acc  = s_if.tvalid & s_if.tready;
    m_xfer = m_if.tvalid & m_if.tready;
    if (lat_chk && pushed_prev) chk("latency", m_if.tvalid, 1'b1);
    if (m_xfer) begin
      if (exp_q.size() == 0) begin
        ncmp++;
        nfail++;
        $error("FAIL unexpected_beat observed=%0h expected=none", m_if.tdata[31:0]);
      end else begin
        e = exp_q.pop_front();
        chk("tdata", m_if.tdata, e.d);
        chk("tkeep", m_if.tkeep, e.k);
        chk("tlast", m_if.tlast, e.l);
        chk("tid", m_if.tid, e.id);
        n_out++;
      end
    end
    pushed_prev = 1'b0;
    if (s_acc) begin
      if (mstate == 0) begin
        mtag = s_if.tdest;
        fwd  = (s_if.tdest == 8'h5C);
        if (!s_if.tlast) mstate = fwd ? 1 : 2;
      end else begin
        fwd = (mstate == 1);
        if (s_if.tdest !== mtag) exp_err = 1'b1;
        if (s_if.tlast) mstate = 0;
      end
      if (fwd) begin
        exp_q.push_back('{d: s_if.tdata, k: s_if.tkeep, l: s_if.tlast, id: s_if.tid});
        pushed_prev = 1'b1;
      end
      if (s_if.tlast) begin
        if (fwd) exp_pkt++;
        else exp_drop++;
      end
    end
    if (cnt_clr) begin
      exp_pkt  = 0;
      exp_drop = 0;
      exp_err  = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_beat(input logic [7:0] dest, input logic [PB-1:0] id, input int idx, input logic last);
    s_if.tvalid = 1'b1;
    s_if.tdest  = dest;
    s_if.tid    = id;
    s_if.tdata  = {16{idx}};
    s_if.tkeep  = {idx, ~idx};
    s_if.tlast  = last;
  endtask

  task automatic send_beat(input logic [7:0] dest, input logic [PB-1:0] id, input int idx, input logic last);
    int g = 0;
    set_beat(dest, id, idx, last);
    do begin
      tick();
      g++;
    end while (!s_acc && g < 50);
    last_g = g;
    if (!s_acc) fail_now("send_beat");
  endtask

  task automatic send_pkt(input logic [7:0] dest, input logic [PB-1:0] id, input int n, input int base, input int bad);
    for (int i = 0; i < n; i++)
      send_beat((i == bad) ? 8'h01 : dest, id, base + i, i == n - 1);
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    s_if.tvalid = 1'b0;
    while ((exp_q.size() > 0 || m_if.tvalid) && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) fail_now("drain");
  endtask

  initial begin
    int j, t, first, last, n0;
    rst = 1'b1;
    cnt_clr = 1'b0;
    m_if.tready = 1'b0;
    set_beat(8'h5C, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_s_tready", s_if.tready, 1'b0);
    chk("rst_route", route_out, 8'h00);
    chk("rst_pkt", pkt_cnt, 32'd0);
    chk("rst_drop", drop_cnt, 32'd0);
    chk("rst_err", route_err, 1'b0);
    s_if.tvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // forwarding
    m_if.tready = 1'b1;
    lat_chk = 1'b1;
    n0 = n_out;
    send_pkt(8'h5C, 3, 4, 100, -1);
    drain();
    lat_chk = 1'b0;
    chk("fwd_beats", n_out - n0, 4);
    chk("fwd_pkt", pkt_cnt, exp_pkt);
    chk("fwd_pkt_one", pkt_cnt, 32'd1);
    chk("fwd_route", route_out, 8'h5C);

    // drop: each beat must be taken in a single cycle
    for (int i = 0; i < 3; i++) begin
      send_beat(8'h7C, 1, 150 + i, i == 2);
      chk("drop_ready", last_g, 1);
    end
    drain();
    chk("drop_cnt", drop_cnt, exp_drop);
    chk("drop_pkt", pkt_cnt, 32'd1);

    // backpressure
    m_if.tready = 1'b0;
    j = 0;
    for (int c = 0; c < 6; c++) begin
      set_beat(8'h5C, 5, 200 + j, j == 7);
      tick();
      if (s_acc) j++;
    end
    chk("bp_accepted", j, 2);
    chk("bp_s_tready", s_if.tready, 1'b0);
    m_if.tready = 1'b1;
    t = 0; first = -1; last = -1; n0 = n_out;
    while ((j < 8 || exp_q.size() > 0) && t < 40) begin
      if (j < 8) set_beat(8'h5C, 5, 200 + j, j == 7);
      else s_if.tvalid = 1'b0;
      tick();
      if (s_acc) j++;
      if (m_xfer) begin
        if (first < 0) first = t;
        last = t;
      end
      t++;
    end
    s_if.tvalid = 1'b0;
    chk("bp_out_beats", n_out - n0, 8);
    chk("bp_out_span", last - first, 7);
    drain();

    // mid-packet tag change
    n0 = n_out;
    send_pkt(8'h5C, 7, 4, 300, 1);
    drain();
    chk("tag_beats", n_out - n0, 4);
    chk("tag_err", route_err, exp_err);
    chk("tag_err_set", route_err, 1'b1);
    repeat (3) tick();
    chk("tag_err_sticky", route_err, 1'b1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_err", route_err, exp_err);
    chk("clr_pkt", pkt_cnt, exp_pkt);
    chk("clr_drop", drop_cnt, 32'd0);

    // back-to-back single-beat packets
    for (int i = 0; i < 20; i++) begin
      set_beat((i % 2) ? 8'h7C : 8'h5C, PB'(i), 400 + i, 1'b1);
      tick();
      chk("single_acc", s_acc, 1'b1);
    end
    drain();
    chk("single_pkt", pkt_cnt, 32'd10);
    chk("single_drop", drop_cnt, 32'd10);
    chk("single_model", pkt_cnt, exp_pkt);

    // reset mid-packet
    send_beat(8'h5C, 2, 500, 1'b0);
    send_beat(8'h5C, 2, 501, 1'b0);
    s_if.tvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_m_tvalid", m_if.tvalid, 1'b0);
    chk("mrst_s_tready", s_if.tready, 1'b0);
    chk("mrst_pkt", pkt_cnt, 32'd0);
    chk("mrst_route", route_out, 8'h00);
    exp_q.delete();
    mstate = 0;
    exp_pkt = 0;
    exp_drop = 0;
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n0 = n_out;
    send_pkt(8'h5C, 2, 3, 502, -1);
    drain();
    chk("mrst_beats", n_out - n0, 3);
    chk("mrst_pkt_after", pkt_cnt, 32'd1);
    chk("mrst_drop_after", drop_cnt, exp_drop);
    chk("mrst_route_after", route_out, 8'h5C);
    chk("final_err", route_err, 1'b0);
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
